// File: rtl/mac24_seq.sv
// mac24_seq: sequential 12x12 unsigned shift-add multiplier feeding a 24-bit
// accumulator with a sticky carry-out flag. One shared 24-bit adder
// (fa24bit_sc) serves both the partial-product additions and the final
// accumulate.
// Optional feature: define MAC24_SEQ_EARLY_EXIT_EN to end the multiply phase
// as soon as the remaining multiplier bits are all zero.

// Ripple-carry 24-bit full adder with carry-in and carry-out.
module fa24bit_sc (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        cin,
    output logic [23:0] sum,
    output logic        cout
);
    logic [24:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[24];
endmodule

module mac24_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [11:0] A_IN,
    input  logic [11:0] B_IN,
    input  logic        ACC_CLR,
    output logic        BUSY,
    output logic        DONE,
    output logic [23:0] ACC,
    output logic        OVF
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [23:0] mcand;
    logic [11:0] mplier;
    logic [23:0] p;
    logic [3:0]  cnt;
    logic [23:0] acc;
    logic        ovf;

    logic [23:0] add_a;
    logic [23:0] add_b;
    logic [23:0] add_sum;
    logic        add_cout;
    logic        mul_last;

    // Shared adder operand select: ACC+P while accumulating, P+MCAND otherwise.
    always_comb begin
        add_a = p;
        add_b = mcand;
        if (state == S_ACCUM) begin
            add_a = acc;
            add_b = p;
        end
    end

    fa24bit_sc u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef MAC24_SEQ_EARLY_EXIT_EN
    // Stop once the multiplier shifted this cycle leaves no set bits.
    assign mul_last = (cnt == 4'd11) || (mplier[11:1] == 11'd0);
`else
    assign mul_last = (cnt == 4'd11);
`endif

    // FSM plus datapath registers; reset clears everything asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            mcand  <= 24'd0;
            mplier <= 12'd0;
            p      <= 24'd0;
            cnt    <= 4'd0;
            acc    <= 24'd0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ACC_CLR) begin
                        acc <= 24'd0;
                        ovf <= 1'b0;
                    end
                    if (START) begin
                        mcand  <= {12'd0, A_IN};
                        mplier <= B_IN;
                        p      <= 24'd0;
                        cnt    <= 4'd0;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Carry-out cannot occur here; the product fits in 24 bits.
                    if (mplier[0]) begin
                        p <= add_sum;
                    end
                    mcand  <= {mcand[22:0], 1'b0};
                    mplier <= {1'b0, mplier[11:1]};
                    cnt    <= cnt + 4'd1;
                    if (mul_last) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= add_sum;
                    if (add_cout) begin
                        ovf <= 1'b1;
                    end
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == S_MUL) || (state == S_ACCUM);
    assign DONE = (state == S_DONE);
    assign ACC  = acc;
    assign OVF  = ovf;
endmodule

// File: tb/tb_mac24_seq.sv
// Directed testbench for mac24_seq. Define MAC24_SEQ_EARLY_EXIT_EN here as
// well as in the RTL to expect the shortened multiply latencies.
module tb_mac24_seq;
    logic        CLK;
    logic        RST;
    logic        START;
    logic [11:0] A_IN;
    logic [11:0] B_IN;
    logic        ACC_CLR;
    logic        BUSY;
    logic        DONE;
    logic [23:0] ACC;
    logic        OVF;

    int checks = 0;
    int errors = 0;

`ifdef MAC24_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mac24_seq dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .A_IN    (A_IN),
        .B_IN    (B_IN),
        .ACC_CLR (ACC_CLR),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ACC     (ACC),
        .OVF     (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one run, observe 20 cycles after the accept edge, then check.
    task automatic run_check(input string name, input logic [11:0] a, input logic [11:0] b,
                             input logic clr, input logic inj,
                             input int lat_def, input int lat_ee,
                             input logic [23:0] exp_mid, input logic [23:0] exp_acc,
                             input logic exp_ovf);
        int lat;
        int done_cyc;
        int busy_cnt;
        int done_cnt;
        logic [23:0] acc_mid;
        lat      = EARLY ? lat_ee : lat_def;
        done_cyc = 0;
        busy_cnt = 0;
        done_cnt = 0;
        acc_mid  = 24'hxxxxxx;
        @(negedge CLK);
        A_IN    = a;
        B_IN    = b;
        ACC_CLR = clr;
        START   = 1'b1;
        @(negedge CLK);
        START   = 1'b0;
        ACC_CLR = 1'b0;
        A_IN    = ~a;
        B_IN    = ~b;
        for (int n = 1; n <= 20; n++) begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (n == lat - 2) acc_mid = ACC;
            if (inj) begin
                if (n == 3 || n == lat - 2) begin
                    START   = 1'b1;
                    ACC_CLR = 1'b1;
                    A_IN    = 12'h0FF;
                    B_IN    = 12'h0FF;
                end else begin
                    START   = 1'b0;
                    ACC_CLR = 1'b0;
                end
            end
            @(negedge CLK);
        end
        START   = 1'b0;
        ACC_CLR = 1'b0;
        $display("run %s: A=0x%03h B=0x%03h clr=%0b ACC=0x%06h OVF=%0b done_cycle=%0d",
                 name, a, b, clr, ACC, OVF, done_cyc);
        check_val({name, ".done_cycle"}, done_cyc, lat);
        check_val({name, ".busy_cycles"}, busy_cnt, lat - 1);
        check_val({name, ".done_pulses"}, done_cnt, 1);
        check_val({name, ".acc_during"}, {8'd0, acc_mid}, {8'd0, exp_mid});
        check_val({name, ".acc"}, {8'd0, ACC}, {8'd0, exp_acc});
        check_val({name, ".ovf"}, {31'd0, OVF}, {31'd0, exp_ovf});
    endtask

    initial begin
        int done_seen;
        RST     = 1'b1;
        START   = 1'b0;
        A_IN    = 12'd0;
        B_IN    = 12'd0;
        ACC_CLR = 1'b0;
        #12;
        check_val("reset.busy", {31'd0, BUSY}, 32'd0);
        check_val("reset.done", {31'd0, DONE}, 32'd0);
        check_val("reset.acc", {8'd0, ACC}, 32'd0);
        check_val("reset.ovf", {31'd0, OVF}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        $display("reset released");

        run_check("mul3x5", 12'h003, 12'h005, 1'b1, 1'b0, 14, 5, 24'h0, 24'h00000F, 1'b0);
        run_check("fff_1", 12'hFFF, 12'hFFF, 1'b1, 1'b0, 14, 14, 24'h0, 24'hFFE001, 1'b0);
        run_check("fff_2", 12'hFFF, 12'hFFF, 1'b0, 1'b0, 14, 14, 24'hFFE001, 24'hFFC002, 1'b1);
        run_check("fff_3", 12'hFFF, 12'hFFF, 1'b0, 1'b0, 14, 14, 24'hFFC002, 24'hFFA003, 1'b1);

        // Clear on its own while idle.
        @(negedge CLK);
        ACC_CLR = 1'b1;
        @(negedge CLK);
        ACC_CLR = 1'b0;
        $display("clear: ACC=0x%06h OVF=%0b", ACC, OVF);
        check_val("clear.acc", {8'd0, ACC}, 32'd0);
        check_val("clear.ovf", {31'd0, OVF}, 32'd0);
        check_val("clear.busy", {31'd0, BUSY}, 32'd0);

        run_check("build100", 12'h010, 12'h010, 1'b0, 1'b0, 14, 7, 24'h0, 24'h000100, 1'b0);
        run_check("start_clr", 12'h002, 12'h003, 1'b1, 1'b0, 14, 4, 24'h0, 24'h000006, 1'b0);
        run_check("ignore_start", 12'h007, 12'h009, 1'b0, 1'b1, 14, 6, 24'h000006, 24'h000045, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge CLK);
        A_IN  = 12'h005;
        B_IN  = 12'hFFF;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        check_val("abort.busy_before", {31'd0, BUSY}, 32'd1);
        #2 RST = 1'b1;
        #1;
        $display("abort: BUSY=%0b DONE=%0b ACC=0x%06h OVF=%0b", BUSY, DONE, ACC, OVF);
        check_val("abort.busy", {31'd0, BUSY}, 32'd0);
        check_val("abort.done", {31'd0, DONE}, 32'd0);
        check_val("abort.acc", {8'd0, ACC}, 32'd0);
        check_val("abort.ovf", {31'd0, OVF}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (DONE) done_seen++;
            @(negedge CLK);
        end
        check_val("abort.no_done", done_seen, 0);
        check_val("abort.acc_after", {8'd0, ACC}, 32'd0);

        run_check("after_rst", 12'h001, 12'h001, 1'b0, 1'b0, 14, 3, 24'h0, 24'h000001, 1'b0);
        run_check("early_a", 12'h00A, 12'h001, 1'b1, 1'b0, 14, 3, 24'h0, 24'h00000A, 1'b0);
        run_check("early_b0", 12'h005, 12'h000, 1'b0, 1'b0, 14, 3, 24'h00000A, 24'h00000A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac24_seq.md
MAC24_SEQ -- requirements
Module: mac24_seq

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 12-bit operands and a 24-bit accumulator.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named CLK and RST.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 START  input  1  request a multiply-accumulate; sampled only in IDLE.
REQ-006 A_IN  input  12  unsigned multiplicand; captured on the accept edge.
REQ-007 B_IN  input  12  unsigned multiplier; captured on the accept edge.
REQ-008 ACC_CLR  input  1  clear ACC and OVF; sampled only in IDLE.
REQ-009 BUSY  output  1  high in states MUL and ACCUM.
REQ-010 DONE  output  1  high for exactly one cycle in state DONE.
REQ-011 ACC  output  24  accumulator register.
REQ-012 OVF  output  1  sticky accumulator carry-out.

Function
REQ-013 The block SHALL use exactly one fa24bit_sc instance for all additions; no other adder SHALL exist in the datapath.
REQ-014 The block SHALL have four FSM states: IDLE, MUL, ACCUM and DONE.
REQ-015 IDLE with START=1 SHALL move to MUL on that edge. The same edge SHALL load MCAND={12'b0,A_IN}, MPLIER=B_IN, P=0 and CNT=0.
REQ-016 In each MUL cycle: if MPLIER[0]=1, P SHALL take the adder SUM of P+MCAND (Cin=0); MCAND SHALL shift left 1, MPLIER SHALL shift right 1, and CNT SHALL increment.
REQ-017 MUL SHALL last exactly 12 cycles (CNT 0..11), then move to ACCUM; the adder Cout SHALL be ignored in MUL.
REQ-018 The ACCUM cycle SHALL compute ACC+P through the shared adder and write SUM to ACC. If Cout=1, OVF SHALL be set. The state SHALL then move to DONE.
REQ-019 DONE SHALL last one cycle, then return to IDLE. Fixed latency: DONE high in the 14th cycle after the accept edge; the next START SHALL be accepted at the earliest on the edge ending DONE+1 (the IDLE cycle).
REQ-020 START in MUL, ACCUM or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 ACC_CLR=1 in IDLE SHALL set ACC=0 and OVF=0 on the next edge. ACC_CLR outside IDLE SHALL be ignored.
REQ-022 START and ACC_CLR both high in IDLE: the clear SHALL apply and the run SHALL accumulate into 0; OVF SHALL start at 0.
REQ-023 ACC SHALL wrap modulo 2^24 on overflow. OVF SHALL remain set until ACC_CLR or RST.
REQ-024 ACC SHALL change only in ACCUM or on a clear. A/B input changes after the accept edge SHALL NOT affect the result.

Reset
REQ-025 RST=1 SHALL immediately force state=IDLE, BUSY=0, DONE=0, ACC=0, OVF=0, P=0, MCAND=0, MPLIER=0 and CNT=0, regardless of CLK.
REQ-026 RST during any state SHALL abort the operation with no partial ACC update. Operation SHALL resume on the first rising edge after RST falls.

Configuration
REQ-027 Macro MAC24_SEQ_EARLY_EXIT_EN SHALL control early termination of the MUL phase.
REQ-028 When MAC24_SEQ_EARLY_EXIT_EN is defined, MUL SHALL end after the cycle in which the shifted MPLIER becomes 0, or at CNT=11, whichever comes first. MUL SHALL always last at least 1 cycle, and latency SHALL equal (MUL cycles)+2.
REQ-029 When MAC24_SEQ_EARLY_EXIT_EN is not defined, MUL SHALL always last 12 cycles, per REQ-017.

Verification
REQ-030 Scenario: RST, ACC_CLR, START A=0x003 B=0x005 -> BUSY high 13 cycles, DONE pulse at cycle 14, ACC=0x00000F, OVF=0.
REQ-031 Scenario: A=0xFFF B=0xFFF from ACC=0 -> ACC=0xFFE001. Repeat twice more -> ACC=0xFFA003 with OVF=1, then ACC_CLR -> ACC=0, OVF=0.
REQ-032 Scenario: pulse START at cycles 3 and 12 of a busy run with other operands -> ignored; result equals that of the first run only, and exactly one DONE pulse.
REQ-033 Scenario: START+ACC_CLR same cycle with ACC=0x000100, A=2 B=3 -> ACC=0x000006.
REQ-034 Scenario: RST asserted in MUL cycle 6 and mid-cycle (no CLK edge) -> outputs zero immediately; no DONE pulse; a subsequent A=1 B=1 run gives ACC=1.
REQ-035 Scenario with MAC24_SEQ_EARLY_EXIT_EN defined: A=0x00A B=0x001 -> DONE in the 3rd cycle after accept, ACC=0x00000A. With B=0x000 -> DONE in the 3rd cycle, ACC unchanged.
